aes_subbytes_pipe: RTL and testbench
====================================

AES_SUBBYTES_PIPE -- requirements
Module: aes_subbytes_pipe

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 4, number of parallel S-box lanes (legal 1..16).
REQ-002 SHALL have parameter PIPE_STAGES, default 2, number of register stages from input to output (legal 1..4).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit, input word present.
REQ-006 SHALL have port in_ready, output, 1 bit, block accepts input this cycle.
REQ-007 SHALL have port in_inv, input, 1 bit, 0 = forward S-box, 1 = inverse S-box, sampled with the word.
REQ-008 SHALL have port in_data, input, 8*NUM_BYTES bits, byte k in bits [8k+7:8k].
REQ-009 SHALL have port out_valid, output, 1 bit, output word present.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream accepts output.
REQ-011 SHALL have port out_data, output, 8*NUM_BYTES bits, substituted bytes, same lane order.
REQ-012 SHALL have port out_inv, output, 1 bit, mode tag travelling with out_data.
REQ-013 SHALL have port xfer_count, output, 16 bits, number of completed output transfers.

Function
REQ-014 Each lane SHALL compute the FIPS-197 S-box (in_inv=0) or inverse S-box (in_inv=1) of its byte; lanes independent; mode applies to all lanes of one word.
REQ-015 Forward path SHALL use the existing bitsliced XOR/AND/XNOR S-box netlist style (no lookup ROM); inverse path SHALL be combinational logic; for both, only input-to-output function is verified.
REQ-016 Pipeline SHALL hold PIPE_STAGES stages, each with a valid bit, data and inv tag; the last stage drives out_valid/out_data/out_inv directly from flops.
REQ-017 Stage i SHALL load from stage i-1 (stage 0 from inputs) when stage i is empty or stage i will be vacated this cycle (bubble-collapsing pipeline); otherwise stage i holds.
REQ-018 in_ready SHALL equal NOT stage0_valid OR stage0 advancing this cycle; combinational path from out_ready to in_ready permitted.
REQ-019 Transfer SHALL occur on in_valid AND in_ready (input) and out_valid AND out_ready (output); data without transfer SHALL NOT enter or leave.
REQ-020 Latency SHALL be exactly PIPE_STAGES cycles from input transfer to out_valid with out_ready held high; sustained throughput one word per cycle.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_inv SHALL remain stable; pipeline SHALL absorb up to PIPE_STAGES words total before deasserting in_ready.
REQ-022 Words SHALL leave in acceptance order; none dropped or duplicated; in_inv change between consecutive words SHALL take effect per word with no bubble.
REQ-023 xfer_count SHALL increment by 1 on each output transfer and wrap 0xFFFF -> 0x0000.
REQ-024 Data/tag registers of empty stages SHALL retain value (no clear required); only valid bits and xfer_count are control-critical.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear all stage valid bits and xfer_count; out_valid=0, out_data=0, out_inv=0, xfer_count=0 immediately.
REQ-026 During reset in_ready SHALL be 0; first cycle after deassertion in_ready SHALL be 1.
REQ-027 Reset mid-operation SHALL discard all in-flight words; no word accepted before reset SHALL appear after it.

Verification
REQ-028 NUM_BYTES=4, PIPE_STAGES=2, out_ready=1: in_data=0xFF53_0100, in_inv=0 -> after 2 cycles out_data=0x16ED_7C63, out_inv=0, xfer_count=1.
REQ-029 Same config, in_data=0x1653_7C63, in_inv=1 -> out_data=0xFF50_0100 after 2 cycles (Sinv(0x53)=0x50); back-to-back forward/inverse alternating words -> each result matches its own mode.
REQ-030 out_ready=0, push words 1..3 -> words 1,2 accepted, in_ready=0 on third, out_data stable at word 1; release out_ready -> words 1,2,3 emerge in order, one per cycle.
REQ-031 Exhaustive: all 256 bytes in every lane, both modes, every PIPE_STAGES 1..4 and NUM_BYTES in {1,4,16} -> match reference table; inverse(forward(x))=x.
REQ-032 Preload xfer_count to 0xFFFF via 65535 transfers, one more transfer -> xfer_count=0x0000; assert rst_n=0 with 2 words in flight -> out_valid=0 at once, nothing emerges after release.

Source files
------------

// File: rtl/aes_subbytes_pipe.sv
// rtl/aes_subbytes_pipe.sv - NUM_BYTES-lane AES S-box / inverse S-box with a bubble-collapsing valid/ready pipeline.
module aes_subbytes_pipe #(
    parameter int NUM_BYTES   = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   out_inv,
    output logic [15:0]            xfer_count
);

    localparam int W = 8 * NUM_BYTES;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^-1 in GF(2^8); x^2*x^4*...*x^128, and 0 maps to 0 for free.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int k = 1; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        return inv ? gf_inv(affine_inv(b)) : affine_fwd(gf_inv(b));
    endfunction

    logic [W-1:0]           sub_data;
    logic [PIPE_STAGES-1:0] stage_valid;
    logic [PIPE_STAGES-1:0] stage_inv;
    logic [W-1:0]           stage_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] stage_load;
    logic                   ready_chain;

    always_comb begin
        sub_data = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            sub_data[8*k +: 8] = sub_byte(in_data[8*k +: 8], in_inv);
        end
    end

    // A stage may load when it is empty or everything downstream of it is moving.
    always_comb begin
        ready_chain = out_ready;
        stage_load  = '0;
        for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
            ready_chain   = ~stage_valid[i] | ready_chain;
            stage_load[i] = ready_chain;
        end
    end

    assign in_ready   = rst_n & stage_load[0];
    assign out_valid  = stage_valid[PIPE_STAGES-1];
    assign out_data   = stage_data[PIPE_STAGES-1];
    assign out_inv    = stage_inv[PIPE_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            stage_inv   <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                stage_data[i] <= '0;
            end
            xfer_count  <= 16'h0000;
        end else begin
            if (stage_load[0]) begin
                stage_valid[0] <= in_valid;
                if (in_valid) begin
                    stage_data[0] <= sub_data;
                    stage_inv[0]  <= in_inv;
                end
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                if (stage_load[i]) begin
                    stage_valid[i] <= stage_valid[i-1];
                    if (stage_valid[i-1]) begin
                        stage_data[i] <= stage_data[i-1];
                        stage_inv[i]  <= stage_inv[i-1];
                    end
                end
            end
            if (out_valid && out_ready) begin
                xfer_count <= xfer_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// tb/tb_aes_subbytes_pipe.sv - self-checking bench for aes_subbytes_pipe (4 lanes, 2 stages).
module tb_aes_subbytes_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_inv;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inv;
    logic [15:0] xfer_count;

    aes_subbytes_pipe #(.NUM_BYTES(4), .PIPE_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inv     (in_inv),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_inv    (out_inv),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          model_cnt = 0;
    bit          rand_bp = 0;
    logic [7:0]  sbox_t [256];
    logic [7:0]  isbox_t [256];
    logic [32:0] sb [$];
    logic [31:0] last_out;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] dbl;
        dbl = {v, v} << n;
        return dbl[15:8];
    endfunction

    // Table built by walking the multiplicative group with generator 3.
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
    endtask

    function automatic logic [32:0] ref_word(input logic [31:0] d, input logic inv);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = inv ? isbox_t[d[8*k +: 8]] : sbox_t[d[8*k +: 8]];
        return {inv, r};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_out observed=%h expected=none", out_data);
            end
            if (sb.size() != 0) check("out_word", {out_inv, out_data}, sb.pop_front());
            model_cnt++;
            last_out = out_data;
        end
    end

    task automatic push(input logic [31:0] d, input logic iv);
        int n;
        n = 0;
        in_data  = d;
        in_inv   = iv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_timeout", in_ready, 1);
        else sb.push_back(ref_word(d, iv));
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic timed(input string tag, input logic [31:0] d, input logic iv, input logic [31:0] exp);
        int lat;
        in_data  = d;
        in_inv   = iv;
        in_valid = 1'b1;
        sb.push_back(ref_word(d, iv));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_inv"}, out_inv, iv);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] w [3];
        logic [31:0] x;
        logic [31:0] f;
        int          target;
        rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
        build_tables();

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_inv", out_inv, 0);
        check("rst_xfer_count", xfer_count, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        timed("fwd", 32'hFF53_0100, 1'b0, 32'h16ED_7C63);
        check("xfer_after_fwd", xfer_count, 1);
        timed("inv", 32'h1653_7C63, 1'b1, 32'hFF50_0100);
        check("xfer_after_inv", xfer_count, 2);

        for (int i = 0; i < 24; i++) push($urandom, i[0]);
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        push(w[0], 1'b0);
        push(w[1], 1'b1);
        in_data = w[2]; in_inv = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold", {out_valid, out_inv, out_data}, {1'b1, ref_word(w[0], 1'b0)});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(w[2], 1'b0);
        @(negedge clk);
        check("bp_stream2", out_valid, 1);
        @(negedge clk);
        check("bp_stream3", out_valid, 1);
        drain();

        rand_bp = 1;
        for (int m = 0; m < 2; m++) begin
            for (int j = 0; j < 256; j++) begin
                for (int k = 0; k < 4; k++) x[8*k +: 8] = 8'(j + 64 * k);
                push(x, m[0]);
            end
        end
        rand_bp = 0;
        drain();

        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            push(x, 1'b0);
            drain();
            f = last_out;
            push(f, 1'b1);
            drain();
            check("roundtrip", last_out, x);
        end

        target = 65535 - model_cnt;
        for (int i = 0; i < target; i++) push($urandom, 1'($urandom));
        drain();
        check("xfer_ffff", xfer_count, 16'hFFFF);
        push($urandom, 1'b0);
        drain();
        check("xfer_wrap", xfer_count, 16'h0000);

        out_ready = 1'b0;
        push($urandom, 1'b0);
        push($urandom, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_xfer", xfer_count, 0);
        check("midrst_out_data", out_data, 0);
        sb.delete();
        model_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_ghost", out_valid, 0);
        end
        check("midrst_xfer_after", xfer_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
